// File: rtl/ifu_rd_responder.sv
// Instruction-fetch read responder: queues up to two AR requests, reads a synchronous
// 64-bit memory after a programmable wait and returns one R beat per request.
module ifu_rd_responder #(
    parameter logic [63:0] ADDR_BASE = 64'h0000_0000_8000_0000,
    parameter int unsigned MEM_AW    = 16,
    parameter int unsigned LAT       = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              ifu_ARVALID,
    output logic              ifu_ARREADY,
    input  logic [63:0]       ifu_ARADDR,
    input  logic [2:0]        ifu_ARPORT,
    output logic              ifu_RVALID,
    input  logic              ifu_RREADY,
    output logic [63:0]       ifu_RDATA,
    output logic [1:0]        ifu_RRESP,
    output logic              mem_en,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [63:0]       mem_rdata
);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;
    localparam logic [3:0] LatLoad    = (LAT == 0) ? 4'd0 : 4'(LAT - 1);

    typedef enum logic [1:0] {StIdle, StWait, StMemrd, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] q_addr_q [2];
    logic [63:0] q_addr_d [2];
    logic        q_instr_q [2];
    logic        q_instr_d [2];
    logic [1:0]  q_resp_q [2];
    logic [1:0]  q_resp_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        rvalid_q, rvalid_d;
    logic [63:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;

    logic [63:0] ar_off;
    logic        ar_in_range;
    logic [1:0]  ar_resp;
    logic        ar_push;
    logic        pop;
    logic        issue;
    logic [63:0] head_addr;
    logic        head_instr;
    logic [1:0]  head_resp;
    logic        unused_port;

    assign unused_port = ^ifu_ARPORT[1:0];

    // Decode happens at push time so the response code travels with the entry.
    always_comb begin
        ar_off      = ifu_ARADDR - ADDR_BASE;
        ar_in_range = (ifu_ARADDR >= ADDR_BASE) && ((ar_off >> (MEM_AW + 3)) == 64'd0);
        if (!ar_in_range) begin
            ar_resp = RespDecErr;
        end else if (ifu_ARPORT[2] && (ifu_ARADDR[1:0] != 2'b00)) begin
            ar_resp = RespSlvErr;
        end else begin
            ar_resp = RespOkay;
        end
    end

    assign ifu_ARREADY = (count_q != 2'd2);
    assign ar_push     = ifu_ARVALID && ifu_ARREADY;

    always_comb begin
        q_addr_d  = q_addr_q;
        q_instr_d = q_instr_q;
        q_resp_d  = q_resp_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (ar_push) begin
            q_addr_d[wr_ptr_q]  = ifu_ARADDR;
            q_instr_d[wr_ptr_q] = ifu_ARPORT[2];
            q_resp_d[wr_ptr_q]  = ar_resp;
            wr_ptr_d            = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({ar_push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    assign head_addr  = q_addr_q[rd_ptr_q];
    assign head_instr = q_instr_q[rd_ptr_q];
    assign head_resp  = q_resp_q[rd_ptr_q];
    assign mem_addr   = MEM_AW'((head_addr - ADDR_BASE) >> 3);
    assign mem_en     = issue && (head_resp == RespOkay);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        issue    = 1'b0;
        pop      = 1'b0;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        unique case (state_q)
            StIdle: begin
                if (count_q != 2'd0) begin
                    if (LAT == 0) begin
                        issue   = 1'b1;
                        state_d = StMemrd;
                    end else begin
                        cnt_d   = LatLoad;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    issue   = 1'b1;
                    state_d = StMemrd;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StMemrd: begin
                pop      = 1'b1;
                rvalid_d = 1'b1;
                rresp_d  = head_resp;
                if (head_resp != RespOkay) begin
                    rdata_d = 64'd0;
                end else if (head_instr) begin
                    rdata_d = head_addr[2] ? {32'h0, mem_rdata[63:32]} : {32'h0, mem_rdata[31:0]};
                end else begin
                    rdata_d = mem_rdata;
                end
                state_d = StResp;
            end
            StResp: begin
                if (ifu_RREADY) begin
                    rvalid_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= 64'd0;
            rresp_q  <= RespOkay;
            for (int i = 0; i < 2; i++) begin
                q_addr_q[i]  <= 64'd0;
                q_instr_q[i] <= 1'b0;
                q_resp_q[i]  <= RespOkay;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            q_addr_q  <= q_addr_d;
            q_instr_q <= q_instr_d;
            q_resp_q  <= q_resp_d;
        end
    end

    assign ifu_RVALID = rvalid_q;
    assign ifu_RDATA  = rdata_q;
    assign ifu_RRESP  = rresp_q;

endmodule

// File: tb/tb_ifu_rd_responder.sv
// Bench for ifu_rd_responder: two instances (LAT=0 and LAT=5), each with its own
// memory model, stimulus thread and scoreboard monitor.
module tb_ifu_rd_responder;
    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
    localparam int unsigned AW   = 16;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic [63:0] idx;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input int lat, input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL L%0d %s: got %0h expected %0h", lat, nm, act, exp);
        end
    endtask

    function automatic logic [63:0] mem_word(input logic [63:0] idx);
        if (idx == 64'd0) return 64'hDEAD_BEEF_0000_0013;
        return {32'hC0DE_0000 ^ idx[31:0], idx[31:0] * 32'h9E37_79B9};
    endfunction

    // Reference: decode rules, then formatting of the addressed memory word.
    function automatic exp_t model(input logic [63:0] a, input logic [2:0] p);
        exp_t        e;
        logic [63:0] w;
        e.idx = (a - BASE) >> 3;
        if (a < BASE || a >= BASE + (64'd8 << AW)) e.resp = 2'b11;
        else if (p[2] && a[1:0] != 2'b00)          e.resp = 2'b10;
        else                                       e.resp = 2'b00;
        w = mem_word(e.idx);
        if (e.resp != 2'b00) e.data = 64'd0;
        else if (p[2])       e.data = a[2] ? {32'h0, w[63:32]} : {32'h0, w[31:0]};
        else                 e.data = w;
        return e;
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam int L = (gi == 0) ? 0 : 5;

        logic          rstn_l = 1'b0;
        logic          arvalid, arready, rvalid, rready, mem_en;
        logic [63:0]   araddr, rdata, mem_rdata;
        logic [2:0]    arport;
        logic [1:0]    rresp;
        logic [AW-1:0] mem_addr;

        exp_t        exp_q[$];
        int          beat_cyc[$];
        int          beats = 0, en_cnt = 0, en_cyc = 0, rv_cyc = 0;
        logic        hold_prev = 1'b0, rv_prev = 1'b0;
        logic [63:0] hold_data = 64'd0, last_rdata = 64'd0;
        logic [1:0]  hold_resp = 2'd0, last_rresp = 2'd0;
        bit          done_l = 1'b0;

        ifu_rd_responder #(
            .ADDR_BASE(BASE),
            .MEM_AW   (AW),
            .LAT      (L)
        ) u_dut (
            .clk        (clk),
            .rstn       (rstn_l),
            .ifu_ARVALID(arvalid),
            .ifu_ARREADY(arready),
            .ifu_ARADDR (araddr),
            .ifu_ARPORT (arport),
            .ifu_RVALID (rvalid),
            .ifu_RREADY (rready),
            .ifu_RDATA  (rdata),
            .ifu_RRESP  (rresp),
            .mem_en     (mem_en),
            .mem_addr   (mem_addr),
            .mem_rdata  (mem_rdata)
        );

        always @(posedge clk) if (mem_en) mem_rdata <= mem_word(64'(mem_addr));

        always @(negedge clk) begin : mon
            exp_t e;
            if (!rstn_l) begin
                hold_prev = 1'b0;
                rv_prev   = 1'b0;
            end else begin
                if (mem_en) begin
                    en_cnt++;
                    en_cyc = cyc;
                    check(L, "en_has_request", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        check(L, "en_head_okay", 64'(exp_q[0].resp), 64'd0);
                        check(L, "mem_addr", 64'(mem_addr), exp_q[0].idx);
                    end
                end
                if (hold_prev) begin
                    check(L, "hold_rvalid", 64'(rvalid), 64'd1);
                    check(L, "hold_rdata", rdata, hold_data);
                    check(L, "hold_rresp", 64'(rresp), 64'(hold_resp));
                end
                if (rvalid && !rv_prev) rv_cyc = cyc;
                if (rvalid && rready) begin
                    beats++;
                    beat_cyc.push_back(cyc);
                    last_rdata = rdata;
                    last_rresp = rresp;
                    check(L, "beat_has_request", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check(L, "sb_rdata", rdata, e.data);
                        check(L, "sb_rresp", 64'(rresp), 64'(e.resp));
                    end
                end
                hold_prev = rvalid && !rready;
                hold_data = rdata;
                hold_resp = rresp;
                rv_prev   = rvalid;
            end
        end

        // Called just after a rising edge; returns the cycle whose edge took the AR.
        task automatic send_ar(input logic [63:0] a, input logic [2:0] p, output int hs);
            hs      = -1;
            arvalid = 1'b1;
            araddr  = a;
            arport  = p;
            for (int n = 0; n < 100; n++) begin
                @(negedge clk);
                if (arready) begin
                    hs = cyc;
                    exp_q.push_back(model(a, p));
                    break;
                end
            end
            check(L, "ar_accepted", 64'(hs >= 0), 64'd1);
            @(posedge clk);
            #1 arvalid = 1'b0;
        endtask

        task automatic wait_beats(input int target);
            for (int n = 0; n < 500; n++) begin
                if (beats >= target) break;
                @(negedge clk);
            end
            check(L, "beats_reached", 64'(beats >= target), 64'd1);
            @(posedge clk);
            #1;
        endtask

        task automatic single_req(input string nm, input logic [63:0] a, input logic [2:0] p,
                                  input logic [1:0] rsp, input int en_exp);
            int hs, b0, e0;
            b0     = beats;
            e0     = en_cnt;
            rready = 1'b1;
            send_ar(a, p, hs);
            wait_beats(b0 + 1);
            check(L, {nm, "_rresp"}, 64'(last_rresp), 64'(rsp));
            check(L, {nm, "_en_pulses"}, 64'(en_cnt - e0), 64'(en_exp));
            check(L, {nm, "_rv_latency"}, 64'(rv_cyc - hs), 64'(3 + L));
            if (rsp != 2'b00) check(L, {nm, "_rdata_zero"}, last_rdata, 64'd0);
        endtask

        initial begin : stim
            int          hs, hs1, hs2, hs3, b0, e0, n_gap;
            logic [63:0] a;
            logic [2:0]  p;
            bit          rnd_done;
            arvalid = 1'b0;
            araddr  = 64'd0;
            arport  = 3'd0;
            rready  = 1'b0;
            rstn_l  = 1'b0;
            repeat (3) @(posedge clk);
            #1 rstn_l = 1'b1;
            @(negedge clk);
            check(L, "rst_arready", 64'(arready), 64'd1);
            check(L, "rst_rvalid", 64'(rvalid), 64'd0);
            check(L, "rst_rdata", rdata, 64'd0);
            check(L, "rst_rresp", 64'(rresp), 64'd0);
            check(L, "rst_mem_en", 64'(mem_en), 64'd0);
            @(posedge clk);
            #1;

            // Single instruction fetch with exact timing.
            rready = 1'b1;
            b0     = beats;
            e0     = en_cnt;
            send_ar(64'h8000_0004, 3'b100, hs);
            wait_beats(b0 + 1);
            check(L, "single_en_cycle", 64'(en_cyc - hs), 64'(1 + L));
            check(L, "single_en_pulses", 64'(en_cnt - e0), 64'd1);
            check(L, "single_rv_cycle", 64'(rv_cyc - hs), 64'(3 + L));
            check(L, "single_rdata", last_rdata, 64'h0000_0000_DEAD_BEEF);
            check(L, "single_rresp", 64'(last_rresp), 64'd0);

            // Decode and error responses, including both range edges.
            single_req("below_base", 64'h7FFF_FFFC, 3'b100, 2'b11, 0);
            single_req("instr_unalign", 64'h8000_0002, 3'b100, 2'b10, 0);
            single_req("data_unalign", 64'h8000_0002, 3'b000, 2'b00, 1);
            single_req("past_top", BASE + 64'h8_0000, 3'b000, 2'b11, 0);
            single_req("last_word", BASE + 64'h7_FFFC, 3'b100, 2'b00, 1);

            // Back-pressure: third AR waits for the first pop; R held stable.
            rready = 1'b0;
            b0     = beats;
            send_ar(64'h8000_0010, 3'b100, hs1);
            send_ar(64'h8000_0018, 3'b000, hs2);
            send_ar(64'h8000_0020, 3'b100, hs3);
            check(L, "bp_second_ar", 64'(hs2 - hs1), 64'd1);
            check(L, "bp_third_ar", 64'(hs3 - hs1), 64'(3 + L));
            repeat (4) @(posedge clk);
            #1 rready = 1'b1;
            wait_beats(b0 + 3);

            // Master issues the next PC in the same cycle it takes each R beat.
            beat_cyc.delete();
            b0 = beats;
            send_ar(64'h8000_0100, 3'b100, hs);
            for (int k = 1; k < 4; k++) begin
                for (int n = 0; n < 50; n++) begin
                    @(posedge clk);
                    #1;
                    if (rvalid) break;
                end
                send_ar(64'h8000_0100 + 64'(4 * k), 3'b100, hs);
            end
            wait_beats(b0 + 4);
            repeat (10) @(posedge clk);
            #1;
            check(L, "mp_beats", 64'(beats - b0), 64'd4);
            if (beat_cyc.size() >= 4) begin
                for (int k = 1; k < 4; k++) begin
                    check(L, "mp_spacing", 64'(beat_cyc[k] - beat_cyc[k-1]), 64'(3 + L));
                end
            end

            // Randomized traffic with random R back-pressure.
            rnd_done = 1'b0;
            fork
                begin
                    for (int n = 0; n < 40; n++) begin
                        case ($urandom_range(0, 3))
                            0: a = BASE + (64'($urandom_range(0, 32'h7FFFF)) & ~64'd3);
                            1: a = BASE + 64'($urandom_range(0, 32'h7FFFF));
                            2: a = BASE - 64'd1 - 64'($urandom_range(0, 32'hFFFF));
                            default: a = BASE + 64'h8_0000 + 64'($urandom_range(0, 32'hFFFF));
                        endcase
                        p     = 3'($urandom_range(0, 7));
                        n_gap = $urandom_range(0, 3);
                        repeat (n_gap) begin
                            @(posedge clk);
                            #1;
                        end
                        send_ar(a, p, hs);
                    end
                    rnd_done = 1'b1;
                end
                begin
                    while (!rnd_done) begin
                        @(posedge clk);
                        #1 rready = 1'($urandom_range(0, 1));
                    end
                end
            join
            rready = 1'b1;
            for (int n = 0; n < 300; n++) begin
                if (exp_q.size() == 0) break;
                @(posedge clk);
                #1;
            end
            check(L, "rand_drained", 64'(exp_q.size()), 64'd0);

            // Reset with two requests in flight: nothing for them may ever appear.
            rready = 1'b0;
            send_ar(64'h8000_0030, 3'b100, hs1);
            send_ar(64'h8000_0038, 3'b000, hs2);
            @(posedge clk);
            #1 rstn_l = 1'b0;
            exp_q.delete();
            #1;
            check(L, "rstmid_rvalid_async", 64'(rvalid), 64'd0);
            check(L, "rstmid_mem_en", 64'(mem_en), 64'd0);
            @(posedge clk);
            #1 rstn_l = 1'b1;
            @(negedge clk);
            check(L, "rstmid_arready", 64'(arready), 64'd1);
            check(L, "rstmid_rvalid", 64'(rvalid), 64'd0);
            check(L, "rstmid_rdata", rdata, 64'd0);
            b0 = beats;
            e0 = en_cnt;
            @(posedge clk);
            #1 rready = 1'b1;
            repeat (12 + L) @(posedge clk);
            #1;
            check(L, "rstmid_no_beat", 64'(beats - b0), 64'd0);
            check(L, "rstmid_no_read", 64'(en_cnt - e0), 64'd0);
            single_req("after_reset", 64'h8000_0008, 3'b000, 2'b00, 1);
            check(L, "after_reset_rdata", last_rdata, mem_word(64'd1));

            done_l = 1'b1;
        end
    end

    initial begin : finish_ctl
        for (int n = 0; n < 40000; n++) begin
            @(posedge clk);
            if (g_dut[0].done_l && g_dut[1].done_l) break;
        end
        check(-1, "all_threads_done", 64'(g_dut[0].done_l && g_dut[1].done_l), 64'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
